// File: rtl/queue_pkg.sv
// Shared defaults for the arbitrated queue and the helper that sizes the
// producer-index field.
package queue_pkg;

  localparam int DEF_WIDTH = 11;
  localparam int DEF_DEPTH = 7;
  localparam int DEF_NREQ  = 4;

  // A single producer still needs one bit so the index field never collapses.
  function automatic int src_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans from last+1 (mod NREQ) and grants
// the first requesting producer, one-hot.
module rr_arbiter
  import queue_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int SRC_W = src_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SRC_W-1:0] last,
  output logic [NREQ-1:0]  gnt
);

  logic found;
  int   idx;

  // NOTE: every output of this block gets a default before the loop, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last) + off) % NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_arb.sv
// Multi-producer FIFO: a round-robin arbiter picks one producer per cycle and
// its data is queued with its index; a single consumer pops with 1-cycle latency.
module queue_arb
  import queue_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NREQ  = DEF_NREQ,
  localparam int SRC_W = src_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [SRC_W-1:0]      rd_src,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH:0]        count
);

  localparam logic [DEPTH:0] CAPACITY = {1'b1, {DEPTH{1'b0}}};

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           mem [2**DEPTH];
  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic [SRC_W-1:0] last_q;
  logic [1:0]       sync_q;
  logic             ready;
  logic [NREQ-1:0]  arb_gnt;
  logic [SRC_W-1:0] gnt_idx;
  logic             push;
  logic             pop;

  // Reset asserts asynchronously but releases through two flops, so nothing
  // is granted or popped until a full clock cycle after reset falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], 1'b1};
  end
  assign ready = sync_q[1];

  rr_arbiter #(
    .NREQ  (NREQ),
    .SRC_W (SRC_W)
  ) u_arb (
    .req  (req),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // Full blocks the grant using the current count, so a pop never bypasses.
  assign full  = (count == CAPACITY);
  assign empty = (count == '0);
  assign gnt   = (ready && !full) ? arb_gnt : '0;
  assign push  = |gnt;
  assign pop   = ready && rd_en && !empty;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_idx = SRC_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_q   <= SRC_W'(NREQ - 1);
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_src   <= '0;
    end else begin
      rd_valid <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        last_q <= gnt_idx;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr].data;
        rd_src  <= mem[rd_ptr].src;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry array has no reset; occupancy is defined by the pointers
  // and count, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{src: gnt_idx, data: wdata[int'(gnt_idx)*WIDTH +: WIDTH]};
  end

endmodule

// File: tb/tb_queue_arb.sv
// Directed bench for queue_arb: table-driven arbitration vectors, then
// hand-written full/empty, ordering and mid-burst reset sequences.
module tb_queue_arb;
  import queue_pkg::*;

  localparam int WIDTH = 11;
  localparam int DEPTH = 7;
  localparam int NREQ  = 4;
  localparam int CAP   = 128;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  rd_en;
  logic [WIDTH-1:0]      rd_data;
  logic [1:0]            rd_src;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic [DEPTH:0]        count;

  queue_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_src   (rd_src),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rd_en;
    logic [3:0] exp_gnt;
    logic [7:0] exp_count;
  } vec_t;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req   = '0;
    rd_en = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    tick;
    tick;
    tick;
  endtask

  vec_t          vecs [14];
  logic [12:0]   mq [$];
  logic [12:0]   exp_item;
  logic [3:0]    r;
  logic [3:0]    eg;
  int            last_m;
  int            pushes;
  int            cyc;
  int            max_count;
  int            idx;
  bit            rd;
  bit            do_pop;

  initial begin
    reset = 1'b1;
    req   = '0;
    rd_en = 1'b0;
    wdata = '0;

    // Round robin with all four requesting, then 0 and 2, then 0 alone.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{req: 4'b1111, rd_en: 1'b0, exp_gnt: 4'(1 << (i % 4)), exp_count: 8'(i)};
    vecs[8]  = '{req: 4'b0101, rd_en: 1'b0, exp_gnt: 4'b0001, exp_count: 8'd8};
    vecs[9]  = '{req: 4'b0101, rd_en: 1'b0, exp_gnt: 4'b0100, exp_count: 8'd9};
    vecs[10] = '{req: 4'b0101, rd_en: 1'b0, exp_gnt: 4'b0001, exp_count: 8'd10};
    vecs[11] = '{req: 4'b0101, rd_en: 1'b0, exp_gnt: 4'b0100, exp_count: 8'd11};
    vecs[12] = '{req: 4'b0001, rd_en: 1'b0, exp_gnt: 4'b0001, exp_count: 8'd12};
    vecs[13] = '{req: 4'b0001, rd_en: 1'b0, exp_gnt: 4'b0001, exp_count: 8'd13};

    do_reset;
    check("reset_count", 32'(count), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);

    for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = 11'(11'h100 + i);
    for (int i = 0; i < 14; i++) begin
      req   = vecs[i].req;
      rd_en = vecs[i].rd_en;
      #1;
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      tick;
    end
    check("vec_end_count", 32'(count), 32'd14);

    // Fill to capacity with producer 0 still requesting.
    req = 4'b0001;
    for (int k = 0; k < 200 && !full; k++) tick;
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'(CAP));
    check("fill_gnt_blocked", 32'(gnt), 32'd0);
    rd_en = 1'b1;
    #1;
    check("full_pop_no_bypass", 32'(gnt), 32'd0);
    tick;
    rd_en = 1'b0;
    #1;
    check("after_pop_full", 32'(full), 32'd0);
    check("after_pop_count", 32'(count), 32'(CAP - 1));
    check("after_pop_gnt", 32'(gnt), 32'b0001);
    check("after_pop_rd_valid", 32'(rd_valid), 32'd1);
    check("after_pop_rd_data", 32'(rd_data), 32'h100);
    check("after_pop_rd_src", 32'(rd_src), 32'd0);
    tick;
    check("refill_full", 32'(full), 32'd1);

    // Pop on empty is ignored, then a single push/pop of 11'h5A3 from producer 2.
    do_reset;
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    check("empty_pop_rd_valid", 32'(rd_valid), 32'd0);
    check("empty_pop_count", 32'(count), 32'd0);
    wdata[2*WIDTH +: WIDTH] = 11'h5A3;
    req = 4'b0100;
    #1;
    check("p2_gnt", 32'(gnt), 32'b0100);
    tick;
    req = '0;
    check("p2_count", 32'(count), 32'd1);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    check("p2_rd_data", 32'(rd_data), 32'h5A3);
    check("p2_rd_src", 32'(rd_src), 32'd2);
    check("p2_rd_valid", 32'(rd_valid), 32'd1);
    check("p2_empty", 32'(empty), 32'd1);
    tick;
    check("p2_rd_valid_one_cycle", 32'(rd_valid), 32'd0);
    check("p2_rd_data_hold", 32'(rd_data), 32'h5A3);

    // 300 pushes interleaved with pops against a reference queue.
    do_reset;
    last_m    = NREQ - 1;
    pushes    = 0;
    cyc       = 0;
    max_count = 0;
    mq.delete();
    while ((pushes < 300 || mq.size() > 0) && cyc < 5000) begin
      r     = (pushes < 300) ? 4'($urandom_range(1, 15)) : 4'b0000;
      rd    = ($urandom_range(0, 9) < 6);
      req   = r;
      rd_en = rd;
      for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = 11'($urandom);
      eg = '0;
      if (mq.size() < CAP) begin
        for (int off = 1; off <= NREQ; off++) begin
          idx = (last_m + off) % NREQ;
          if (eg == '0 && r[idx]) eg[idx] = 1'b1;
        end
      end
      #1;
      check("stream_count", 32'(count), 32'(mq.size()));
      check("stream_gnt", 32'(gnt), 32'(eg));
      if (int'(count) > max_count) max_count = int'(count);
      do_pop = rd && (mq.size() > 0);
      if (do_pop) exp_item = mq.pop_front();
      for (int i = 0; i < NREQ; i++) begin
        if (eg[i]) begin
          mq.push_back({2'(i), wdata[i*WIDTH +: WIDTH]});
          last_m = i;
          pushes++;
        end
      end
      tick;
      check("stream_rd_valid", 32'(rd_valid), 32'(do_pop));
      if (do_pop) begin
        check("stream_rd_data", 32'(rd_data), 32'(exp_item[10:0]));
        check("stream_rd_src", 32'(rd_src), 32'(exp_item[12:11]));
      end
      cyc++;
    end
    req   = '0;
    rd_en = 1'b0;
    check("stream_done_in_budget", 32'(cyc < 5000), 32'd1);
    check("stream_pushes", 32'(pushes), 32'd300);
    check("stream_max_count_le_cap", 32'(max_count <= CAP), 32'd1);

    // Reset mid-burst at count=5 with rd_valid high.
    do_reset;
    req = 4'b0001;
    for (int k = 0; k < 5; k++) tick;
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    check("burst_count", 32'(count), 32'd5);
    check("burst_rd_valid", 32'(rd_valid), 32'd1);
    req   = 4'b1110;
    reset = 1'b1;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    tick;
    reset = 1'b0;
    #1;
    check("release_gnt_held", 32'(gnt), 32'd0);
    for (int k = 0; k < 10 && gnt == '0; k++) tick;
    check("post_reset_first_gnt", 32'(gnt), 32'b0010);
    req = '0;
    tick;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
